// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_arb_pkg;

    localparam int NUM_REQ = 3;

    // Requester indices into REQ / DATA_IN / GNT
    localparam int REQ_BTN = 0;
    localparam int REQ_ROT = 1;
    localparam int REQ_KEY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    // Index to one-hot requester mask
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == 2'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches REQ (minus EXCL) starting
// one past LAST, wrapping modulo NUM_REQ; the first set bit wins.
module rr_pick
    import led_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [1:0]         LAST,
    input  logic [NUM_REQ-1:0] EXCL,
    output logic               VALID,
    output logic [1:0]         IDX,
    output logic [NUM_REQ-1:0] ONEHOT
);

    logic [NUM_REQ-1:0] cand;
    logic [1:0]         pos [NUM_REQ];

    assign cand = REQ & ~EXCL;

    // pos[k] is the requester examined at search step k
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_order
        assign pos[gi] = 2'((int'(LAST) + 1 + gi) % NUM_REQ);
    end

    // Walk the search order backwards so the earliest candidate is written last
    always_comb begin
        VALID = 1'b0;
        IDX   = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand[pos[k]]) begin
                VALID = 1'b1;
                IDX   = pos[k];
            end
        end
    end

    assign ONEHOT = VALID ? idx_to_onehot(IDX) : '0;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the 8-bit LED bank with a post-release hold window
// and an optional grant time limit while other requesters are waiting.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int MAX_GRANT   = 0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [2:0]  REQ,
    input  logic [23:0] DATA_IN,
    output logic [2:0]  GNT,
    output logic [7:0]  LED,
    output logic        BUSY
);

    localparam int CNT_SPAN = (HOLD_CYCLES > MAX_GRANT) ? HOLD_CYCLES : MAX_GRANT;
    localparam int CNT_W    = $clog2(CNT_SPAN) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GRANT_LAST = (MAX_GRANT > 0) ? CNT_W'(MAX_GRANT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_t          state_reg;
    logic [NUM_REQ-1:0]  gnt_reg;
    logic [7:0]          led_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [1:0]          last_reg;
    logic [1:0]          owner_reg;

    logic [7:0]          slice [NUM_REQ];
    logic                owner_req;
    logic                force_rot;
    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [NUM_REQ-1:0]  pick_onehot;

    // Split the packed pattern bus into one byte per requester
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign slice[gi] = DATA_IN[gi*8 +: 8];
    end

    assign owner_req = |(REQ & gnt_reg);

    // Excluding the current owner is harmless outside forced rotation: in IDLE
    // nobody is granted, and at HOLD expiry the owner's REQ is already low.
    rr_pick u_pick (
        .REQ    (REQ),
        .LAST   (last_reg),
        .EXCL   (gnt_reg),
        .VALID  (pick_valid),
        .IDX    (pick_idx),
        .ONEHOT (pick_onehot)
    );

    assign force_rot = (MAX_GRANT > 0) && (cnt_reg == GRANT_LAST) && owner_req && pick_valid;

    // Arbitration FSM with registered GNT/LED and shared grant/hold counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            led_reg   <= 8'h00;
            cnt_reg   <= '0;
            last_reg  <= 2'(REQ_KEY);
            owner_reg <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg <= GRANT;
                        gnt_reg   <= pick_onehot;
                        led_reg   <= slice[pick_idx];
                        cnt_reg   <= '0;
                        last_reg  <= pick_idx;
                        owner_reg <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                    end else if (force_rot) begin
                        gnt_reg   <= pick_onehot;
                        led_reg   <= slice[pick_idx];
                        cnt_reg   <= '0;
                        last_reg  <= pick_idx;
                        owner_reg <= pick_idx;
                    end else begin
                        led_reg <= slice[owner_reg];
                        if (cnt_reg != CNT_SAT) begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (owner_req) begin
                        state_reg <= GRANT;
                        cnt_reg   <= '0;
                        led_reg   <= slice[owner_reg];
                    end else if (cnt_reg == HOLD_LAST) begin
                        cnt_reg <= '0;
                        if (pick_valid) begin
                            state_reg <= GRANT;
                            gnt_reg   <= pick_onehot;
                            led_reg   <= slice[pick_idx];
                            last_reg  <= pick_idx;
                            owner_reg <= pick_idx;
                        end else begin
                            state_reg <= IDLE;
                            gnt_reg   <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign GNT  = gnt_reg;
    assign LED  = led_reg;
    assign BUSY = (state_reg != IDLE);

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: the stimulus process queues the expected
// outputs for each applied cycle, a monitor pops and compares after each edge.
module tb_led_arbiter;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [2:0]  REQ;
    logic [23:0] DATA_IN;
    logic [2:0]  GNT;
    logic [7:0]  LED;
    logic        BUSY;

    typedef struct {
        logic [2:0] gnt;
        logic [7:0] led;
        logic       busy;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    led_arbiter #(
        .HOLD_CYCLES (4),
        .MAX_GRANT   (6)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .REQ     (REQ),
        .DATA_IN (DATA_IN),
        .GNT     (GNT),
        .LED     (LED),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    // Monitor: compare DUT outputs 2 time units after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (GNT !== e.gnt || LED !== e.led || BUSY !== e.busy) begin
                    failures++;
                    $display("FAIL step%0d: got gnt=%b led=%h busy=%b, want gnt=%b led=%h busy=%b",
                             e.id, GNT, LED, BUSY, e.gnt, e.led, e.busy);
                end else begin
                    $display("step%0d ok gnt=%b led=%h busy=%b", e.id, GNT, LED, BUSY);
                end
            end
        end
    end

    // Apply inputs at the falling edge and queue the outputs expected after the next rising edge
    task automatic step(input logic [2:0] r, input logic [23:0] d,
                        input logic [2:0] eg, input logic [7:0] el, input logic eb);
        exp_t e;
        REQ     = r;
        DATA_IN = d;
        e.gnt   = eg;
        e.led   = el;
        e.busy  = eb;
        e.id    = step_no;
        exp_q.push_back(e);
        step_no++;
        @(negedge CLK);
    endtask

    task automatic direct_check(input string name, input logic [10:0] act, input logic [10:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end else begin
            $display("%s ok value=%h", name, act);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        REQ     = 3'b000;
        DATA_IN = 24'h0;
        @(negedge CLK);

        // 1. reset held for 3 cycles, then idle after release
        repeat (3) step(3'b000, 24'h0, 3'b000, 8'h00, 1'b0);
        RESET_N = 1'b1;
        step(3'b000, 24'h0, 3'b000, 8'h00, 1'b0);

        // 2. single request tracking: LAST=2 -> only req1 set, it wins
        step(3'b010, 24'h000F00, 3'b010, 8'h0F, 1'b1);
        step(3'b010, 24'h00F000, 3'b010, 8'hF0, 1'b1);
        step(3'b010, 24'h00F000, 3'b010, 8'hF0, 1'b1);
        // 5. sole owner drops: 4 HOLD cycles, then IDLE keeping LED
        step(3'b000, 24'h00F000, 3'b010, 8'hF0, 1'b1);
        repeat (3) step(3'b000, 24'h00F000, 3'b010, 8'hF0, 1'b1);
        step(3'b000, 24'h00F000, 3'b000, 8'hF0, 1'b0);

        // 1b. asynchronous reset in the middle of a grant
        step(3'b100, 24'hAA0000, 3'b100, 8'hAA, 1'b1);
        #2 RESET_N = 1'b0;
        #1;
        direct_check("async_rst_gnt",  {8'h00, GNT},  11'h000);
        direct_check("async_rst_led",  {3'b000, LED}, 11'h000);
        direct_check("async_rst_busy", {10'h000, BUSY}, 11'h000);
        @(negedge CLK);
        repeat (2) step(3'b100, 24'hAA0000, 3'b000, 8'h00, 1'b0);
        RESET_N = 1'b1;
        step(3'b000, 24'h030201, 3'b000, 8'h00, 1'b0);

        // 3. contention after reset: req0 wins, drops, 4-cycle hold, req1 next
        step(3'b111, 24'h030201, 3'b001, 8'h01, 1'b1);
        step(3'b111, 24'h030201, 3'b001, 8'h01, 1'b1);
        step(3'b111, 24'h030201, 3'b001, 8'h01, 1'b1);
        step(3'b110, 24'h030201, 3'b001, 8'h01, 1'b1);
        repeat (3) step(3'b110, 24'h030201, 3'b001, 8'h01, 1'b1);
        step(3'b110, 24'h030201, 3'b010, 8'h02, 1'b1);

        // 4. owner req1 drops, returns on 3rd HOLD cycle while req2 waits
        step(3'b100, 24'h030201, 3'b010, 8'h02, 1'b1);
        step(3'b100, 24'h030201, 3'b010, 8'h02, 1'b1);
        step(3'b100, 24'h030201, 3'b010, 8'h02, 1'b1);
        step(3'b110, 24'h032201, 3'b010, 8'h22, 1'b1);
        step(3'b110, 24'h032301, 3'b010, 8'h23, 1'b1);
        step(3'b010, 24'h032301, 3'b010, 8'h23, 1'b1);
        // 5b. drop again with nothing pending: idle with LED kept
        step(3'b000, 24'h032301, 3'b010, 8'h23, 1'b1);
        repeat (3) step(3'b000, 24'h032301, 3'b010, 8'h23, 1'b1);
        step(3'b000, 24'h032301, 3'b000, 8'h23, 1'b0);

        // 6. forced rotation: req0 held, req2 raised on cycle 1
        step(3'b001, 24'h0C0B0A, 3'b001, 8'h0A, 1'b1);
        repeat (5) step(3'b101, 24'h0C0B0A, 3'b001, 8'h0A, 1'b1);
        step(3'b101, 24'h0C0B0A, 3'b100, 8'h0C, 1'b1);
        step(3'b101, 24'h0D0B0A, 3'b100, 8'h0D, 1'b1);
        step(3'b001, 24'h0D0B0A, 3'b100, 8'h0D, 1'b1);
        repeat (3) step(3'b001, 24'h0D0B0A, 3'b100, 8'h0D, 1'b1);
        step(3'b001, 24'h0D0B0A, 3'b001, 8'h0A, 1'b1);
        step(3'b001, 24'h0D0B5A, 3'b001, 8'h5A, 1'b1);
        step(3'b000, 24'h0D0B5A, 3'b001, 8'h5A, 1'b1);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge CLK);
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
